uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Parametrised successor to the digital-clock UART receive path: a UART byte receiver plus a framed-packet assembler in one block.
- Accepts packets of the form HEADER, PAYLOAD_BYTES data bytes, then an 8-bit checksum.
- Publishes the payload as one wide register after the checksum verifies.
- Adds glitch rejection, stop-bit checking, checksum checking and inter-byte timeout, none of which the fixed-width receiver has.
- Sits between the board RX pin and the command decoder.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate. BIT_CNT = CLK_FREQ/BAUD (integer division) clocks per bit; BIT_CNT >= 8.
- PAYLOAD_BYTES, 17, number of payload bytes per frame (>= 1).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CLKS, 10*BIT_CNT*4, idle clocks allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first
- byte_data  output  8  last received byte
- byte_valid  output  1  one-cycle pulse; byte_data is new
- frame_data  output  PAYLOAD_BYTES*8  last good payload; first payload byte in the MSBs
- frame_valid  output  1  one-cycle pulse; frame_data is updated
- err_frame  output  1  one-cycle pulse on a bad stop bit
- err_chk  output  1  one-cycle pulse on a checksum mismatch
- err_timeout  output  1  one-cycle pulse on inter-byte timeout
- busy  output  1  high while the frame FSM is not in F_HDR

Behaviour:
- Reset: all outputs are 0, FSMs are idle, and the synchroniser is preset to 1 (idle line).
- uart_rxd passes through a 2-FF synchroniser. All references to "rxd" below mean the synchronised signal.
- Byte FSM:
  - B_IDLE: on a falling edge of rxd go to B_START and clear the bit counter.
  - B_START: at clock count BIT_CNT/2, sample rxd. If high, treat it as a glitch: return to B_IDLE with no pulse. If low, go to B_DATA.
  - B_DATA: sample 8 bits, each BIT_CNT clocks after the previous sample, shifting LSB first.
  - B_STOP: sample BIT_CNT clocks after the last data bit.
    - Sample 1: byte_data is loaded and byte_valid pulses on the next clock.
    - Sample 0: err_frame pulses on the next clock, and the byte is discarded.
  - After B_STOP, return to B_IDLE immediately. Falling-edge detect is active from the cycle after the stop sample.
- Frame FSM (consumes good bytes only):
  - F_HDR:
    - A byte equal to HEADER clears the checksum accumulator and the byte index, then goes to F_PAY.
    - Any other byte is silently ignored.
  - F_PAY:
    - Each byte goes into a shadow payload register at position (PAYLOAD_BYTES-1-index) and is added to the accumulator (8-bit sum, mod 256).
    - After byte PAYLOAD_BYTES, go to F_CHK.
    - A byte equal to HEADER is treated as data, not as a resync.
  - F_CHK:
    - Byte equals the accumulator: copy the shadow register to frame_data and pulse frame_valid one clock after the corresponding byte_valid.
    - Otherwise pulse err_chk in that same cycle, and frame_data is unchanged.
    - Either way, return to F_HDR.
- err_frame while in F_PAY or F_CHK aborts the frame to F_HDR. The shadow register is discarded.
- Timeout counter:
  - Counts only in F_PAY or F_CHK while the byte FSM is in B_IDLE.
  - Clears on any byte_valid.
  - On reaching TIMEOUT_CLKS: pulse err_timeout and go to F_HDR.
- Only one error or valid pulse fires per cycle; they are mutually exclusive by construction.
- frame_data holds its value indefinitely between good frames.
- Asserting rst mid-byte or mid-frame aborts everything immediately with no pulses. After release, a partially received frame is never completed.

Test Plan (CLK_FREQ=16, BAUD=1 so BIT_CNT=16; PAYLOAD_BYTES=3; HEADER=A5; TIMEOUT_CLKS=400):
- Send A5 01 02 03 06 → five byte_valid pulses; frame_valid once, one clock after the last byte_valid; frame_data=24'h010203; no error pulses; busy low afterwards.
- Send A5 01 02 03 07 → err_chk pulse once; frame_valid never pulses; frame_data keeps its previous value.
- Send 00 FF A5 10 20 30 60 → the first two bytes are ignored; frame_data=24'h102030.
- Send A5 11 with the stop bit of 11 held low → err_frame pulses; busy drops. Then A5 01 02 03 06 → frame completes normally.
- Drive uart_rxd low for 3 clocks only → no byte_valid and no error pulse; byte FSM back in B_IDLE.
- Send A5 01, then idle 400 clocks → err_timeout pulses once; then A5 AA BB CC 31 → frame_data=24'hAABBCC. Separately, assert rst mid-payload → all outputs 0 on the next edge.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// Signal bundle between the UART frame receiver and its host.
// The host drives the serial line; the receiver drives everything else.
interface uart_frame_rx_if #(
    parameter int PAYLOAD_BYTES = 17
);
    logic                       uart_rxd;
    logic [7:0]                 byte_data;
    logic                       byte_valid;
    logic [PAYLOAD_BYTES*8-1:0] frame_data;
    logic                       frame_valid;
    logic                       err_frame;
    logic                       err_chk;
    logic                       err_timeout;
    logic                       busy;

    modport master (
        output uart_rxd,
        input  byte_data, byte_valid, frame_data, frame_valid,
        input  err_frame, err_chk, err_timeout, busy
    );

    modport slave (
        input  uart_rxd,
        output byte_data, byte_valid, frame_data, frame_valid,
        output err_frame, err_chk, err_timeout, busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART byte receiver feeding a HEADER/payload/checksum frame assembler.
// The payload is published as one wide register once the checksum matches.
module uart_frame_rx #(
    parameter int          CLK_FREQ      = 50_000_000,
    parameter int          BAUD          = 115200,
    parameter int          PAYLOAD_BYTES = 17,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int          TIMEOUT_CLKS  = 10 * (CLK_FREQ / BAUD) * 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_frame_rx_if.slave bus
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_CNT);
    localparam int IW      = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam int FW      = PAYLOAD_BYTES * 8;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} b_state_t;
    typedef enum logic [1:0] {F_HDR, F_PAY, F_CHK} f_state_t;

    b_state_t        b_state, b_next;
    f_state_t        f_state, f_next;
    logic [2:0]      sync;
    logic            rxd, rxd_d, tick;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg, byte_data, acc;
    logic            byte_valid, err_frame, frame_valid, err_chk, err_timeout;
    logic [FW-1:0]   shadow, frame_data;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tcnt;
    logic            tmo_en, tmo_hit, good_chk, bad_chk;
    int              pos;

    // sync[2] is one cycle behind rxd, giving the falling-edge reference
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 3'b111;
        else     sync <= {sync[1:0], bus.uart_rxd};

    assign rxd   = sync[1];
    assign rxd_d = sync[2];
    assign tick  = (b_state == B_START) ? (cnt == CW'(BIT_CNT / 2))
                                        : (cnt == CW'(BIT_CNT - 1));

    always_ff @(posedge clk or posedge rst)
        if (rst) b_state <= B_IDLE;
        else     b_state <= b_next;

    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE:  if (rxd_d && !rxd) b_next = B_START;
            B_START: if (tick) b_next = rxd ? B_IDLE : B_DATA;
            B_DATA:  if (tick && bit_idx == 3'd7) b_next = B_STOP;
            B_STOP:  if (tick) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            cnt        <= (b_state == B_IDLE || tick) ? '0 : cnt + 1'b1;
            if (b_state == B_START) bit_idx <= '0;
            if (b_state == B_DATA && tick) begin
                shreg   <= {rxd, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (b_state == B_STOP && tick) begin
                if (rxd) begin
                    byte_data  <= shreg;
                    byte_valid <= 1'b1;
                end else begin
                    err_frame  <= 1'b1;
                end
            end
        end

    assign tmo_en = (f_state != F_HDR) && (b_state == B_IDLE);

    always_ff @(posedge clk or posedge rst)
        if (rst) f_state <= F_HDR;
        else     f_state <= f_next;

    // A bad stop bit or a finished byte takes priority over the timeout,
    // which keeps all result pulses mutually exclusive.
    always_comb begin
        f_next   = f_state;
        tmo_hit  = 1'b0;
        good_chk = 1'b0;
        bad_chk  = 1'b0;
        pos      = 8 * (PAYLOAD_BYTES - 1 - int'(idx));
        if (f_state != F_HDR && err_frame) begin
            f_next = F_HDR;
        end else if (byte_valid) begin
            case (f_state)
                F_HDR: if (byte_data == HEADER) f_next = F_PAY;
                F_PAY: if (int'(idx) == PAYLOAD_BYTES - 1) f_next = F_CHK;
                F_CHK: begin
                    f_next = F_HDR;
                    if (byte_data == acc) good_chk = 1'b1;
                    else                  bad_chk  = 1'b1;
                end
                default: f_next = F_HDR;
            endcase
        end else if (tmo_en && tcnt == TW'(TIMEOUT_CLKS - 1)) begin
            tmo_hit = 1'b1;
            f_next  = F_HDR;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc         <= '0;
            idx         <= '0;
            shadow      <= '0;
            tcnt        <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_valid <= good_chk;
            err_chk     <= bad_chk;
            err_timeout <= tmo_hit;
            if (good_chk) frame_data <= shadow;
            if (byte_valid && f_state == F_HDR) begin
                acc <= '0;
                idx <= '0;
            end else if (byte_valid && f_state == F_PAY) begin
                shadow[pos +: 8] <= byte_data;
                acc              <= acc + byte_data;
                idx              <= idx + 1'b1;
            end
            if (byte_valid || err_frame || tmo_hit || f_state == F_HDR) tcnt <= '0;
            else if (tmo_en)                                           tcnt <= tcnt + 1'b1;
        end

    assign bus.byte_data   = byte_data;
    assign bus.byte_valid  = byte_valid;
    assign bus.frame_data  = frame_data;
    assign bus.frame_valid = frame_valid;
    assign bus.err_frame   = err_frame;
    assign bus.err_chk     = err_chk;
    assign bus.err_timeout = err_timeout;
    assign bus.busy        = (f_state != F_HDR);
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed and randomized frames against a byte-sequence reference model.
module tb_uart_frame_rx;
    localparam int         BIT = 16;
    localparam int         PB  = 3;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus ();

    uart_frame_rx #(
        .CLK_FREQ(16), .BAUD(1), .PAYLOAD_BYTES(PB), .HEADER(HDR), .TIMEOUT_CLKS(400)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_bv = 0, n_fv = 0, n_ef = 0, n_ec = 0, n_et = 0, n_multi = 0;
    int last_bv_cyc = 0, last_fv_cyc = 0;
    int s_bv, s_fv, s_ef, s_ec, s_et;
    logic [23:0] exp_fd = 24'h0;

    always @(negedge clk) begin
        cyc++;
        if (bus.byte_valid)  begin n_bv++; last_bv_cyc = cyc; end
        if (bus.frame_valid) begin n_fv++; last_fv_cyc = cyc; end
        if (bus.err_frame)   n_ef++;
        if (bus.err_chk)     n_ec++;
        if (bus.err_timeout) n_et++;
        if (int'(bus.byte_valid) + int'(bus.frame_valid) + int'(bus.err_frame)
            + int'(bus.err_chk) + int'(bus.err_timeout) > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_bv = n_bv; s_fv = n_fv; s_ef = n_ef; s_ec = n_ec; s_et = n_et;
    endtask

    task automatic deltas(input string tag, input int bv, input int fv, input int ef,
                          input int ec, input int et);
        chk({tag, ".byte_valid"},  64'(n_bv - s_bv), 64'(bv));
        chk({tag, ".frame_valid"}, 64'(n_fv - s_fv), 64'(fv));
        chk({tag, ".err_frame"},   64'(n_ef - s_ef), 64'(ef));
        chk({tag, ".err_chk"},     64'(n_ec - s_ec), 64'(ec));
        chk({tag, ".err_timeout"}, 64'(n_et - s_et), 64'(et));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        bus.uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        bus.uart_rxd = stop;
        repeat (BIT) @(negedge clk);
        bus.uart_rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1, 16 + int'($urandom_range(0, 48)));
    endtask

    // Scan a clean byte stream starting outside any frame: find a header,
    // take PB payload bytes and a checksum, compare with the byte sum.
    function automatic void model(input logic [7:0] q[$], output int nf, output int nc,
                                  inout logic [23:0] fd);
        int i = 0;
        nf = 0; nc = 0;
        while (i < q.size()) begin
            if (q[i] != HDR || i + PB + 1 >= q.size()) begin
                i++;
            end else begin
                logic [7:0]  sum = 8'h0;
                logic [23:0] pay = 24'h0;
                for (int k = 1; k <= PB; k++) begin
                    sum += q[i+k];
                    pay = {pay[15:0], q[i+k]};
                end
                if (q[i+PB+1] == sum) begin nf++; fd = pay; end
                else                  nc++;
                i += PB + 2;
            end
        end
    endfunction

    initial begin
        logic [7:0] q[$];
        int nf, nc;
        bus.uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.byte_valid", 64'(bus.byte_valid), 64'd0);
        chk("reset.frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("reset.errors", 64'({bus.err_frame, bus.err_chk, bus.err_timeout}), 64'd0);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.byte_data", 64'(bus.byte_data), 64'd0);
        chk("reset.frame_data", 64'(bus.frame_data), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        snap();
        q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06};
        send_q(q);
        deltas("good", 5, 1, 0, 0, 0);
        chk("good.frame_data", 64'(bus.frame_data), 64'h010203);
        chk("good.fv_after_bv", 64'(last_fv_cyc - last_bv_cyc), 64'd1);
        chk("good.byte_data", 64'(bus.byte_data), 64'h06);
        chk("good.busy", 64'(bus.busy), 64'd0);
        exp_fd = 24'h010203;

        snap();
        q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h07};
        send_q(q);
        deltas("badsum", 5, 0, 0, 1, 0);
        chk("badsum.frame_data", 64'(bus.frame_data), 64'(exp_fd));

        snap();
        q = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h60};
        send_q(q);
        deltas("junk", 7, 1, 0, 0, 0);
        chk("junk.frame_data", 64'(bus.frame_data), 64'h102030);
        exp_fd = 24'h102030;

        snap();
        send_byte(8'hA5, 1'b1, 16);
        chk("stop.busy_mid", 64'(bus.busy), 64'd1);
        send_byte(8'h11, 1'b0, 16);
        deltas("stop", 1, 0, 1, 0, 0);
        chk("stop.busy", 64'(bus.busy), 64'd0);
        snap();
        q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06};
        send_q(q);
        deltas("stop.recover", 5, 1, 0, 0, 0);
        chk("stop.frame_data", 64'(bus.frame_data), 64'h010203);
        exp_fd = 24'h010203;

        snap();
        bus.uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        deltas("glitch", 0, 0, 0, 0, 0);
        chk("glitch.busy", 64'(bus.busy), 64'd0);

        snap();
        send_byte(8'hA5, 1'b1, 16);
        send_byte(8'h01, 1'b1, 16);
        repeat (300) @(negedge clk);
        deltas("tmo.early", 2, 0, 0, 0, 0);
        chk("tmo.busy_early", 64'(bus.busy), 64'd1);
        repeat (150) @(negedge clk);
        deltas("tmo", 2, 0, 0, 0, 1);
        chk("tmo.busy", 64'(bus.busy), 64'd0);
        snap();
        q = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        send_q(q);
        deltas("tmo.recover", 5, 1, 0, 0, 0);
        chk("tmo.frame_data", 64'(bus.frame_data), 64'hAABBCC);
        exp_fd = 24'hAABBCC;

        for (int r = 0; r < 6; r++) begin
            logic [7:0] sum, b;
            q = {};
            for (int j = int'($urandom_range(0, 2)); j > 0; j--) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(HDR);
            sum = 8'h0;
            for (int k = 0; k < PB; k++) begin
                b = 8'($urandom);
                sum += b;
                q.push_back(b);
            end
            q.push_back($urandom_range(0, 1) ? sum : sum ^ 8'($urandom_range(1, 255)));
            model(q, nf, nc, exp_fd);
            snap();
            send_q(q);
            deltas($sformatf("rand%0d", r), q.size(), nf, 0, nc, 0);
            chk($sformatf("rand%0d.frame_data", r), 64'(bus.frame_data), 64'(exp_fd));
        end

        send_byte(8'hA5, 1'b1, 16);
        send_byte(8'h01, 1'b1, 16);
        bus.uart_rxd = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.outputs", 64'({bus.byte_valid, bus.frame_valid, bus.err_frame,
                                bus.err_chk, bus.err_timeout, bus.busy}), 64'd0);
        chk("rst.byte_data", 64'(bus.byte_data), 64'd0);
        chk("rst.frame_data", 64'(bus.frame_data), 64'd0);
        bus.uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        snap();
        q = '{8'h03, 8'h06};
        send_q(q);
        deltas("rst.after", 2, 0, 0, 0, 0);
        chk("rst.busy_after", 64'(bus.busy), 64'd0);

        chk("exclusive", 64'(n_multi), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
